// File: rtl/seg_readback.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_readback
// Watches a multiplexed, active-low seven-segment display bus and rebuilds the
// multi-digit BCD value it shows. Each digit dwell is debounced and decoded back
// to BCD. A frame is published once every digit position has been captured.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg[6:0]     active-low segments, bit6=a ... bit0=g
//   dig_sel      active-high one-hot digit enable, bit i = digit i
//   clr          synchronous clear of the partial frame
//   value        last completed frame, digit i at [4i+3:4i]
//   frame_valid  one-cycle pulse when value updates
//   frame_err    qualified by frame_valid: some digit in the frame was invalid
//   err_mask     qualified by frame_valid: bit i set if digit i was invalid
// -----------------------------------------------------------------------------
module seg_readback #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     dig_sel,
   input  logic                  clr,
   output logic [4*DIGITS-1:0]   value,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic [DIGITS-1:0]     err_mask
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HELD
   } state_t;

   // Input stage
   logic [6:0]              r_seg;
   logic [DIGITS-1:0]       r_sel;

   // Filter FSM
   state_t                  r_state;
   state_t                  w_state_next;
   logic [3:0]              r_cnt;
   logic [3:0]              w_cnt_next;
   logic [3:0]              w_cnt_inc;
   logic                    w_onehot;
   logic                    w_same;
   logic                    w_capture;

   // Decoder
   logic [3:0]              w_code;
   logic                    w_invalid;

   // Partial frame and published frame
   logic [DIGITS-1:0][3:0]  r_digit;
   logic [DIGITS-1:0][3:0]  w_digit_cap;
   logic [DIGITS-1:0]       r_errbits;
   logic [DIGITS-1:0]       w_err_cap;
   logic [DIGITS-1:0]       r_bitmap;
   logic [DIGITS-1:0]       w_bitmap_cap;
   logic                    w_complete;
   logic [4*DIGITS-1:0]     r_value;
   logic [DIGITS-1:0]       r_err_mask;
   logic                    r_frame_err;
   logic                    r_frame_valid;

   assign value       = r_value;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign err_mask    = r_err_mask;

   // NOTE: sequential state uses non-blocking (<=) assignments so every
   // register samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= '1;
         r_sel <= '0;
      end else begin
         r_seg <= seg;
         r_sel <= dig_sel;
      end
   end

   // The registered pair is "stable" on an edge when the sample about to be
   // taken equals the one already held. Requiring STABLE_CYCLES such edges,
   // with the first pin sample landing in r_seg/r_sel, means the pins must
   // hold for STABLE_CYCLES+1 edges and the capture falls on the last one.
   assign w_onehot  = $onehot(r_sel);
   assign w_same    = (seg == r_seg) && (dig_sel == r_sel);
   assign w_cnt_inc = r_cnt + 4'd1;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_code    = 4'hE;
      w_invalid = 1'b1;
      case (r_seg)
         7'b0000001: begin w_code = 4'h0; w_invalid = 1'b0; end
         7'b1001111: begin w_code = 4'h1; w_invalid = 1'b0; end
         7'b0010010: begin w_code = 4'h2; w_invalid = 1'b0; end
         7'b0000110: begin w_code = 4'h3; w_invalid = 1'b0; end
         7'b1001100: begin w_code = 4'h4; w_invalid = 1'b0; end
         7'b0100100: begin w_code = 4'h5; w_invalid = 1'b0; end
         7'b0100000: begin w_code = 4'h6; w_invalid = 1'b0; end
         7'b0001111: begin w_code = 4'h7; w_invalid = 1'b0; end
         7'b0000000: begin w_code = 4'h8; w_invalid = 1'b0; end
         7'b0000100: begin w_code = 4'h9; w_invalid = 1'b0; end
         7'b1111111: begin w_code = 4'hF; w_invalid = 1'b0; end
         default:    begin w_code = 4'hE; w_invalid = 1'b1; end
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      if (!w_onehot) begin
         w_state_next = ST_IDLE;
         w_cnt_next   = 4'd0;
      end else if (!w_same) begin
         w_state_next = ST_SETTLE;
         w_cnt_next   = 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_next = ST_SETTLE;
               w_cnt_next   = 4'd1;
            end
            ST_SETTLE: begin
               w_cnt_next = w_cnt_inc;
               if (w_cnt_inc == STABLE_CNT) begin
                  w_capture    = 1'b1;
                  w_state_next = ST_HELD;
               end
            end
            ST_HELD: begin
               // Counter stays saturated for the rest of the dwell.
               w_state_next = ST_HELD;
               w_cnt_next   = r_cnt;
            end
            default: begin
               w_state_next = ST_IDLE;
               w_cnt_next   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else if (clr) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Partial frame as it would look after this edge's capture, so the
   // completing digit is included in the published value.
   always_comb begin
      w_digit_cap  = r_digit;
      w_err_cap    = r_errbits;
      w_bitmap_cap = r_bitmap | r_sel;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_sel[i]) begin
            w_digit_cap[i] = w_code;
            w_err_cap[i]   = w_invalid;
         end
      end
   end

   assign w_complete = w_capture && (w_bitmap_cap == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the digit store is a handful of flops, not a RAM, so it is
         // reset along with the rest to discard any partial frame.
         r_digit       <= '0;
         r_errbits     <= '0;
         r_bitmap      <= '0;
         r_value       <= '0;
         r_err_mask    <= '0;
         r_frame_err   <= 1'b0;
         r_frame_valid <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         if (clr) begin
            // Clear wins over a coinciding capture; published frame untouched.
            r_digit   <= '0;
            r_errbits <= '0;
            r_bitmap  <= '0;
         end else if (w_capture) begin
            r_digit <= w_digit_cap;
            if (w_complete) begin
               r_value       <= w_digit_cap;
               r_err_mask    <= w_err_cap;
               r_frame_err   <= |w_err_cap;
               r_frame_valid <= 1'b1;
               r_bitmap      <= '0;
               r_errbits     <= '0;
            end else begin
               r_bitmap  <= w_bitmap_cap;
               r_errbits <= w_err_cap;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_readback.sv
`timescale 1ns/1ps
module tb_seg_readback;

   localparam int DIGITS = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   dig_sel;
   logic                clr;
   logic [4*DIGITS-1:0] value;
   logic                frame_valid;
   logic                frame_err;
   logic [DIGITS-1:0]   err_mask;

   seg_readback #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .clr         (clr),
      .value       (value),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .err_mask    (err_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] code;
      logic       err;
   } vec_t;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  mask;
      logic        ferr;
   } frame_t;

   frame_t exp_q[$];
   vec_t   tbl[16];
   int     n_vec = 0;
   int     n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every frame_valid pulse must match the oldest expected frame.
   frame_t mon_e;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && frame_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got value %0h, expected no frame", value);
         end else begin
            mon_e = exp_q.pop_front();
            check("frame_value", 32'(value), 32'(mon_e.value));
            check("frame_mask", 32'(err_mask), 32'(mon_e.mask));
            check("frame_err", 32'(frame_err), 32'(mon_e.ferr));
         end
      end
   end

   // Hold a pair at the pins across n rising edges, returning on a falling edge.
   task automatic drive(input logic [3:0] sel, input logic [6:0] sg, input int n);
      dig_sel = sel;
      seg     = sg;
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_frame(input logic [15:0] v, input logic [3:0] m, input logic f);
      frame_t e;
      e.value = v;
      e.mask  = m;
      e.ferr  = f;
      exp_q.push_back(e);
   endtask

   task automatic idle_check(input string name);
      drive(4'b0000, 7'h7F, 3);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] v;
      logic [3:0]  m;

      tbl[0]  = '{7'b0000001, 4'h0, 1'b0};
      tbl[1]  = '{7'b1001111, 4'h1, 1'b0};
      tbl[2]  = '{7'b0010010, 4'h2, 1'b0};
      tbl[3]  = '{7'b0000110, 4'h3, 1'b0};
      tbl[4]  = '{7'b1001100, 4'h4, 1'b0};
      tbl[5]  = '{7'b0100100, 4'h5, 1'b0};
      tbl[6]  = '{7'b0100000, 4'h6, 1'b0};
      tbl[7]  = '{7'b0001111, 4'h7, 1'b0};
      tbl[8]  = '{7'b0000000, 4'h8, 1'b0};
      tbl[9]  = '{7'b0000100, 4'h9, 1'b0};
      tbl[10] = '{7'b1111111, 4'hF, 1'b0};
      tbl[11] = '{7'b1111110, 4'hE, 1'b1};
      tbl[12] = '{7'b0111111, 4'hE, 1'b1};
      tbl[13] = '{7'b1000000, 4'hE, 1'b1};
      tbl[14] = '{7'b0101010, 4'hE, 1'b1};
      tbl[15] = '{7'b1010101, 4'hE, 1'b1};

      // Reset state
      rst_n   = 1'b0;
      clr     = 1'b0;
      seg     = 7'h7F;
      dig_sel = '0;
      @(negedge clk);
      check("reset_value", 32'(value), 32'd0);
      check("reset_fv", 32'(frame_valid), 32'd0);
      check("reset_mask", 32'(err_mask), 32'd0);
      check("reset_ferr", 32'(frame_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic frame 5413
      expect_frame(16'h5413, 4'b0000, 1'b0);
      drive(4'b0001, 7'b0000110, 6);
      drive(4'b0010, 7'b1001111, 6);
      drive(4'b0100, 7'b1001100, 6);
      drive(4'b1000, 7'b0100100, 6);
      idle_check("basic_pending");

      // Decode table, four digits per frame, back-to-back dwells
      for (int f = 0; f < 4; f++) begin
         v = '0;
         m = '0;
         for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = tbl[4*f+i].code;
            m[i]        = tbl[4*f+i].err;
         end
         expect_frame(v, m, |m);
         for (int i = 0; i < DIGITS; i++)
            drive(4'(1 << i), tbl[4*f+i].seg, 6);
      end
      idle_check("table_pending");

      // Invalid digit plus blank
      expect_frame(16'hFE21, 4'b0100, 1'b1);
      drive(4'b0001, 7'b1001111, 6);
      drive(4'b0010, 7'b0010010, 6);
      drive(4'b0100, 7'b0101010, 6);
      drive(4'b1000, 7'b1111111, 6);
      idle_check("invalid_pending");

      // Glitch: one edge short, then a 2-edge blip; digit 0 must stay uncaptured
      drive(4'b0001, 7'b0100100, 4);
      drive(4'b0001, 7'b0000110, 2);
      drive(4'b0000, 7'h7F, 3);
      drive(4'b0010, 7'b0000000, 6);
      drive(4'b0100, 7'b0000100, 6);
      drive(4'b1000, 7'b0100000, 6);
      idle_check("glitch_no_frame");
      expect_frame(16'h6987, 4'b0000, 1'b0);
      drive(4'b0001, 7'b0001111, 6);
      idle_check("glitch_pending");

      // Non-one-hot selects never capture
      drive(4'b0011, 7'b0000001, 20);
      drive(4'b0000, 7'b0000001, 20);
      drive(4'b0100, 7'b0010010, 6);
      drive(4'b1000, 7'b0000110, 6);
      idle_check("nonhot_no_frame");
      expect_frame(16'h3254, 4'b0000, 1'b0);
      drive(4'b0001, 7'b1001100, 6);
      drive(4'b0010, 7'b0100100, 6);
      idle_check("nonhot_pending");

      // Asynchronous reset mid-frame
      drive(4'b0001, 7'b1001111, 6);
      drive(4'b0010, 7'b0010010, 6);
      dig_sel = 4'b0100;
      seg     = 7'b0000110;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_value", 32'(value), 32'd0);
      check("async_rst_fv", 32'(frame_valid), 32'd0);
      check("async_rst_mask", 32'(err_mask), 32'd0);
      check("async_rst_ferr", 32'(frame_err), 32'd0);
      @(negedge clk);
      dig_sel = '0;
      seg     = 7'h7F;
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0100, 7'b0100000, 6);
      drive(4'b1000, 7'b0001111, 6);
      idle_check("rst_no_frame");
      check("rst_value_held", 32'(value), 32'd0);
      expect_frame(16'h7698, 4'b0000, 1'b0);
      drive(4'b0001, 7'b0000000, 6);
      drive(4'b0010, 7'b0000100, 6);
      idle_check("rst_pending");

      // clr after three digits discards them
      drive(4'b0001, 7'b1001111, 6);
      drive(4'b0010, 7'b0010010, 6);
      drive(4'b0100, 7'b0000110, 6);
      drive(4'b0000, 7'h7F, 2);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      drive(4'b1000, 7'b0000001, 6);
      idle_check("clr_no_frame");
      check("clr_value_kept", 32'(value), 32'h7698);
      // Digit 3 from after the clr completes the next scan at digit 2
      expect_frame(16'h0654, 4'b0000, 1'b0);
      drive(4'b0001, 7'b1001100, 6);
      drive(4'b0010, 7'b0100100, 6);
      drive(4'b0100, 7'b0100000, 6);
      drive(4'b1000, 7'b0000001, 6);
      idle_check("clr_scan_pending");

      // clr on the completing edge suppresses the frame
      drive(4'b0001, 7'b0000000, 6);
      drive(4'b0010, 7'b0000100, 6);
      dig_sel = 4'b0100;
      seg     = 7'b0000110;
      repeat (4) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      check("clr_complete_fv", 32'(frame_valid), 32'd0);
      check("clr_complete_value", 32'(value), 32'h0654);
      idle_check("clr_complete_no_frame");
      expect_frame(16'h4321, 4'b0000, 1'b0);
      drive(4'b0001, 7'b1001111, 6);
      drive(4'b0010, 7'b0010010, 6);
      drive(4'b0100, 7'b0000110, 6);
      drive(4'b1000, 7'b1001100, 6);
      idle_check("final_pending");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
